// File: rtl/alu_exec_ctrl.sv
// Operand/select staging ahead of the ALU result mux, plus result capture and
// N/Z/C/V flag generation toward writeback over a valid/ready handshake.
module alu_exec_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [3:0]   op_code,
    input  logic [N-1:0] operand_a,
    input  logic [N-1:0] operand_b,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   select_alu,
    input  logic [N-1:0] alu_result,
    output logic         wb_valid,
    input  logic         wb_ready,
    output logic [N-1:0] wb_result,
    output logic [3:0]   wb_flags,
    output logic         op_err
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] alu_a_q, alu_a_d;
    logic [N-1:0] alu_b_q, alu_b_d;
    logic [3:0]   sel_q, sel_d;
    logic [N-1:0] res_q, res_d;
    logic [3:0]   flags_q, flags_d;
    logic         err_q, err_d;

    logic legal;
    logic flag_n, flag_z, flag_c, flag_v;
    logic same_sign, res_flip;

    assign legal = (op_code[3:2] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            alu_a_q <= '0;
            alu_b_q <= '0;
            sel_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (op_valid && legal) state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      if (wb_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Carry without a wide adder: a+b overflows N bits exactly when a > ~b.
    always_comb begin
        same_sign = (alu_a_q[N-1] == alu_b_q[N-1]);
        res_flip  = (alu_result[N-1] != alu_a_q[N-1]);
        flag_n    = alu_result[N-1];
        flag_z    = (alu_result == '0);
        flag_c    = 1'b0;
        flag_v    = 1'b0;
        if (sel_q == OP_ADD) begin
            flag_c = (alu_a_q > ~alu_b_q);
            flag_v = same_sign && res_flip;
        end else if (sel_q == OP_SUB) begin
            flag_c = (alu_a_q >= alu_b_q);
            flag_v = !same_sign && res_flip;
        end
    end

    always_comb begin
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        sel_d   = sel_q;
        res_d   = res_q;
        flags_d = flags_q;
        err_d   = 1'b0;
        if (state_q == IDLE && op_valid) begin
            if (legal) begin
                alu_a_d = operand_a;
                alu_b_d = operand_b;
                sel_d   = op_code;
            end else begin
                err_d = 1'b1;
            end
        end
        if (state_q == EXEC) begin
            res_d   = alu_result;
            flags_d = {flag_n, flag_z, flag_c, flag_v};
        end
    end

    always_comb begin
        op_ready   = (state_q == IDLE);
        wb_valid   = (state_q == WB);
        alu_a      = alu_a_q;
        alu_b      = alu_b_q;
        select_alu = sel_q;
        wb_result  = res_q;
        wb_flags   = flags_q;
        op_err     = err_q;
    end

endmodule
